grf_multiport: RTL and testbench
================================

# grf_multiport

Parametrised general register file for the pipelined MIPS core: configurable data width, depth and read-port count, with optional write-to-read bypass and a per-register pending-write scoreboard. It sits between decode and writeback. It replaces the fixed 32×32, two-read, one-write register file. Decode uses the scoreboard to detect RAW hazards against in-flight producers.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see stored value only
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all registers and busy bits
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port i register has a pending write not satisfied this cycle
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- busy_set  in  1  mark register busy_addr as pending (producer issued)
- busy_addr  in  ADDR_W  register being claimed

## Operation
- Register 0 is hardwired zero. Reads return 0. Writes and busy_set to 0 are ignored. rd_busy for address 0 is always 0.
- Read path is combinational per port:
  - If BYPASS=1, we=1, wa==rd_addr[i] and wa!=0, then rd_data[i]=wd.
  - Otherwise rd_data[i]=mem[rd_addr[i]].
- Write: if we=1 and wa!=0, then mem[wa] <= wd at the rising edge.
- Scoreboard: one busy bit per register.
  - busy_set (addr≠0) sets busy[busy_addr].
  - we (wa≠0) clears busy[wa].
  - Same edge, same address, set and clear: set wins. A new producer supersedes the completing one; data is still written.
  - Same edge, different addresses: both take effect.
- rd_busy[i] = busy[rd_addr[i]] & ~(BYPASS & we & wa==rd_addr[i]).
  - It reflects current state only; a busy_set in the same cycle does not affect it.
- Reset dominates: when reset=1, we and busy_set are ignored for that edge.
- Multiple read ports addressing the same register return identical data and busy.

## Timing
- Reset values after the reset edge: every mem entry = 0, every busy bit = 0. Hence all rd_data = 0 and all rd_busy = 0 for any address.
- Read latency: 0 cycles (combinational from rd_addr, we, wa, wd).
- Write latency:
  - BYPASS=0: visible on reads 1 cycle after the write edge.
  - BYPASS=1: visible in the same cycle as we.
- Busy set at edge N: rd_busy high from cycle N+1.
- Busy clear by write at edge N:
  - BYPASS=1: rd_busy low in cycle N already (bypass masks it).
  - BYPASS=0: rd_busy low from cycle N+1.
- Reset mid-operation: pending busy bits are dropped. No writeback is remembered; a later we to a non-busy register is a plain write.
- No handshake back-pressure. The block accepts one write and one busy_set every cycle.

## Structure
- Shared package grf_pkg holds:
  - default DATA_W/ADDR_W
  - ZERO_REG constant (0)
  - port-slice helper functions for rd_addr/rd_data packing
- Sub-module grf_scoreboard (2**ADDR_W busy bits, set/clear priority, reset) is instantiated once.
- Storage array and bypass muxes are generated per read port in the top.

## Test plan
- Reset then read: assert reset 1 cycle with we=1, wa=4, wd=1 → mem[4]=0 afterwards; all rd_data=0, all rd_busy=0.
- Write then read, BYPASS=1: we=1, wa=4, wd=1, rd_addr0=4 → rd_data0=1 in the same cycle; next cycle with we=0, still 1. Repeat with BYPASS=0 → old value (0) in the same cycle, 1 next cycle.
- Zero register: we=1, wa=0, wd=32'hDEADBEEF and busy_set to 0 → rd_data for address 0 = 0, rd_busy=0, on every port.
- Scoreboard: busy_set addr 7 at edge N → rd_busy=1 from N+1. At edge N+3, we to 7 with wd=32'h55 → BYPASS=1: rd_busy=0 and rd_data=32'h55 in that cycle.
- Set/clear collision: busy[9]=1, then same edge we to 9 (wd=3) and busy_set 9 → mem[9]=3, busy[9] stays 1, rd_busy=1 next cycle.
- Reset mid-flight: busy bits on 3, 5, 31, reset for one cycle → all rd_busy=0. A subsequent write to 5 with wd=8 reads back 8.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared definitions for the general register file: default geometry, the
// hardwired zero register, and helpers for the packed per-port buses.
package grf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  // Low bit of port `port` within a packed bus made of `width`-bit fields.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

  // The zero register has no storage or scoreboard state behind it.
  function automatic bit is_zero_reg(input int addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/grf_multiport_scoreboard.sv
// Pending-write scoreboard: one busy bit per register. Set marks an issued
// producer, clear marks its writeback. When both hit one register, set wins.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  output logic [(2**ADDR_W)-1:0] busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             set_ok;
  logic             clr_ok;

  assign set_ok = set_en && (set_addr != ZERO_ADDR);
  assign clr_ok = clr_en && (clr_addr != ZERO_ADDR);

  always_comb begin
    busy_d = busy_q;
    // Clear applied first so a same-register set overrides it.
    if (clr_ok) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (set_ok) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/grf_multiport.sv
// Parametrised multi-read-port register file with optional write-to-read
// bypass and a pending-write scoreboard for decode-stage RAW detection.
module grf_multiport
  import grf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic BYP = (BYPASS != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok;

  assign wr_ok = we && (wa != ZERO_ADDR);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[wa] = wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  grf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (busy_set),
    .set_addr (busy_addr),
    .clr_en   (we),
    .clr_addr (wa),
    .busy     (busy)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[slice_lo(p, ADDR_W) +: ADDR_W];
    // A same-cycle writeback both forwards its data and satisfies the pending bit.
    assign hit  = BYP && wr_ok && (wa == addr);
    assign data = (addr == ZERO_ADDR) ? '0 :
                  hit                 ? wd :
                                        mem_q[addr];

    assign rd_data[slice_lo(p, DATA_W) +: DATA_W] = data;
    assign rd_busy[p] = busy[addr] & ~hit;
  end

endmodule

// File: tb/tb_grf_multiport.sv
// Scoreboard bench for grf_multiport: one BYPASS=1 and one BYPASS=0 instance
// driven in lockstep, expectations queued by the driver and checked on negedge.
module tb_grf_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic          busy_set;
  logic [AW-1:0] busy_addr;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_busy_b, rd_busy_n;

  always #5 clk = ~clk;

  grf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .we(we), .wa(wa), .wd(wd),
    .busy_set(busy_set), .busy_addr(busy_addr)
  );

  grf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_busy(rd_busy_n), .we(we), .wa(wa), .wd(wd),
    .busy_set(busy_set), .busy_addr(busy_addr)
  );

  typedef struct {
    string       name;
    int          dut;   // 0 = bypass instance, 1 = no-bypass instance
    int          port;
    logic [31:0] d;
    logic        b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic drive(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic bs,
                       input logic [AW-1:0] ba, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1);
    reset     = r;
    we        = w;
    wa        = a;
    wd        = d;
    busy_set  = bs;
    busy_addr = ba;
    rd_addr   = {a1, a0};
  endtask

  task automatic exp_both(input string nm, input int port,
                          input logic [31:0] d_byp, input logic b_byp,
                          input logic [31:0] d_nob, input logic b_nob);
    exp_t e;
    e.name = nm; e.port = port;
    e.dut = 0; e.d = d_byp; e.b = b_byp; exp_q.push_back(e);
    e.dut = 1; e.d = d_nob; e.b = b_nob; exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are combinational, so every queued entry for the
  // current cycle is checked on the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act_d;
    logic        act_b;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.dut == 0) begin
        act_d = rd_data_b[e.port*DW +: DW];
        act_b = rd_busy_b[e.port];
      end else begin
        act_d = rd_data_n[e.port*DW +: DW];
        act_b = rd_busy_n[e.port];
      end
      n_cmp++;
      if (act_d !== e.d) begin
        n_bad++;
        $display("FAIL %s dut%0d port%0d data: got %h want %h",
                 e.name, e.dut, e.port, act_d, e.d);
      end
      n_cmp++;
      if (act_b !== e.b) begin
        n_bad++;
        $display("FAIL %s dut%0d port%0d busy: got %b want %b",
                 e.name, e.dut, e.port, act_b, e.b);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // C0: reset with a write and busy_set that must both be dropped
    drive(1, 1, 5'd4, 32'd1, 1, 5'd4, 5'd4, 5'd0);
    next_cycle();
    // C1: reset state
    drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd4, 5'd31);
    exp_both("reset_r4", 0, 32'd0, 0, 32'd0, 0);
    exp_both("reset_r31", 1, 32'd0, 0, 32'd0, 0);
    next_cycle();
    // C2: write 4 <= 1
    drive(0, 1, 5'd4, 32'd1, 0, 5'd0, 5'd4, 5'd5);
    exp_both("wr_same_cycle", 0, 32'd1, 0, 32'd0, 0);
    exp_both("wr_other_reg", 1, 32'd0, 0, 32'd0, 0);
    next_cycle();
    // C3: visible on both after the edge
    drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd4, 5'd4);
    exp_both("wr_next_p0", 0, 32'd1, 0, 32'd1, 0);
    exp_both("wr_next_p1", 1, 32'd1, 0, 32'd1, 0);
    next_cycle();
    // C4: zero register write and busy_set
    drive(0, 1, 5'd0, 32'hDEADBEEF, 1, 5'd0, 5'd0, 5'd0);
    exp_both("zero_same_p0", 0, 32'd0, 0, 32'd0, 0);
    exp_both("zero_same_p1", 1, 32'd0, 0, 32'd0, 0);
    next_cycle();
    // C5: zero still zero; busy_set 7 (edge N) not visible this cycle
    drive(0, 0, 5'd0, 32'd0, 1, 5'd7, 5'd0, 5'd7);
    exp_both("zero_after", 0, 32'd0, 0, 32'd0, 0);
    exp_both("set_same_cycle", 1, 32'd0, 0, 32'd0, 0);
    next_cycle();
    // C6, C7: busy from N+1
    drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd7, 5'd7);
    exp_both("busy7_n1_p0", 0, 32'd0, 1, 32'd0, 1);
    exp_both("busy7_n1_p1", 1, 32'd0, 1, 32'd0, 1);
    next_cycle();
    exp_both("busy7_n2", 0, 32'd0, 1, 32'd0, 1);
    next_cycle();
    // C8: writeback to 7 at N+3
    drive(0, 1, 5'd7, 32'h55, 0, 5'd0, 5'd7, 5'd7);
    exp_both("wb7_p0", 0, 32'h55, 0, 32'd0, 1);
    exp_both("wb7_p1", 1, 32'h55, 0, 32'd0, 1);
    next_cycle();
    // C9: cleared on both; claim 9
    drive(0, 0, 5'd0, 32'd0, 1, 5'd9, 5'd7, 5'd9);
    exp_both("wb7_after", 0, 32'h55, 0, 32'h55, 0);
    exp_both("claim9_same", 1, 32'd0, 0, 32'd0, 0);
    next_cycle();
    // C10: write 9 and re-claim 9 on the same edge
    drive(0, 1, 5'd9, 32'd3, 1, 5'd9, 5'd9, 5'd9);
    exp_both("coll_same", 0, 32'd3, 0, 32'd0, 1);
    next_cycle();
    // C11: data written, set wins
    drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd9, 5'd9);
    exp_both("coll_after_p0", 0, 32'd3, 1, 32'd3, 1);
    exp_both("coll_after_p1", 1, 32'd3, 1, 32'd3, 1);
    next_cycle();
    // C12: clear 9 and set 10 on the same edge
    drive(0, 1, 5'd9, 32'd4, 1, 5'd10, 5'd9, 5'd10);
    exp_both("diff_wr9", 0, 32'd4, 0, 32'd3, 1);
    exp_both("diff_set10", 1, 32'd0, 0, 32'd0, 0);
    next_cycle();
    // C13: both took effect; claim 3
    drive(0, 0, 5'd0, 32'd0, 1, 5'd3, 5'd9, 5'd10);
    exp_both("diff_after9", 0, 32'd4, 0, 32'd4, 0);
    exp_both("diff_after10", 1, 32'd0, 1, 32'd0, 1);
    next_cycle();
    // C14, C15: claim 5 and 31
    drive(0, 0, 5'd0, 32'd0, 1, 5'd5, 5'd3, 5'd5);
    exp_both("claim3", 0, 32'd0, 1, 32'd0, 1);
    next_cycle();
    drive(0, 0, 5'd0, 32'd0, 1, 5'd31, 5'd3, 5'd5);
    exp_both("claim5", 1, 32'd0, 1, 32'd0, 1);
    next_cycle();
    // C16: reset with a competing write and claim
    drive(1, 1, 5'd5, 32'd77, 1, 5'd5, 5'd31, 5'd5);
    next_cycle();
    // C17: everything dropped
    drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd31, 5'd5);
    exp_both("mid_rst_r31", 0, 32'd0, 0, 32'd0, 0);
    exp_both("mid_rst_r5", 1, 32'd0, 0, 32'd0, 0);
    next_cycle();
    // C18: plain write to 5
    drive(0, 1, 5'd5, 32'd8, 0, 5'd0, 5'd5, 5'd3);
    exp_both("post_rst_wr5", 0, 32'd8, 0, 32'd0, 0);
    exp_both("post_rst_r3", 1, 32'd0, 0, 32'd0, 0);
    next_cycle();
    // C19: readback and reset-cleared storage
    drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd5, 5'd9);
    exp_both("post_rst_rd5", 0, 32'd8, 0, 32'd8, 0);
    exp_both("post_rst_r9", 1, 32'd0, 0, 32'd0, 0);
    next_cycle();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
